button_event: RTL and testbench
===============================

Name: button_event

Overview:
- Sits directly downstream of the button debouncer in the digital clock.
- Consumes the debounced "button held" level and classifies each press as short or long.
- After a long press is recognised, emits auto-repeat steps while the button stays held.
- Feeds the time-set logic (hour/minute increment) with single-cycle event pulses.

Parameters:
- CNT_W, 10, width of the hold/repeat tick counter.
- LONG_TICKS, 800, ticks of continuous hold before a press counts as long. Legal range 1..2^CNT_W-1.
- REPEAT_TICKS, 200, ticks between auto-repeat pulses in the LONG state. 0 disables repeat. Legal range 0..2^CNT_W-1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- tick  input  1  single-cycle timebase enable (1 ms nominal), synchronous to clk.
- pressed  input  1  debounced level, high while the button is held.
- short_pulse  output  1  one cycle: released before the long threshold.
- long_pulse  output  1  one cycle: hold reached LONG_TICKS.
- repeat_pulse  output  1  one cycle: each auto-repeat interval while in LONG.
- step_pulse  output  1  one cycle: OR of short/long/repeat, for increment logic.
- long_active  output  1  level, high while in LONG.

Behaviour:
- **Reset (async):**
  - state=IDLE, counter=0.
  - All outputs 0.
  - Reset mid-press aborts the press with no pulse. After reset release, a still-high pressed input starts a fresh press.
- **Outputs:**
  - All outputs are registered.
  - Pulses are exactly one clk cycle wide and mutually exclusive.
  - step_pulse is asserted in the same cycle as whichever pulse fires.
- **FSM states:** IDLE, PRESS, LONG.
- **IDLE:**
  - pressed=1 -> PRESS, counter=0.
  - tick in this cycle is not counted.
- **PRESS:**
  - pressed=0 -> IDLE; short_pulse=1 next cycle.
  - else if tick and counter==LONG_TICKS-1 -> LONG, counter=0; long_pulse=1 next cycle.
  - else if tick -> counter+1.
- **LONG:**
  - pressed=0 -> IDLE, no pulse.
  - else if tick and REPEAT_TICKS!=0 and counter==REPEAT_TICKS-1 -> counter=0; repeat_pulse=1 next cycle.
  - else if tick and REPEAT_TICKS!=0 -> counter+1.
  - long_active=1 from the cycle long_pulse is asserted until the cycle after pressed falls.
- **Latency:**
  - short_pulse: 1 cycle after pressed is sampled low in PRESS.
  - long_pulse / repeat_pulse: 1 cycle after the qualifying tick is sampled.
- **Simultaneous events:** release and the qualifying tick in the same cycle -> release wins (short_pulse in PRESS, silent exit in LONG).
- **Counter:**
  - Unsigned CNT_W bits, compared for equality only, never wraps.
  - It is cleared on every state entry.
  - tick held high continuously is legal: each high cycle counts as one tick.
- **Glitches:** a one-cycle pressed high->low->high produces short_pulse then a new PRESS; no filtering here (the debouncer owns that).
- **Legality checks:** parameter legality checked by elaboration-time assertion. LONG_TICKS=1 means the first tick in PRESS yields long.

Decomposition:
- Shared package clock_pkg holds:
  - btn_state_t enum {BTN_IDLE, BTN_PRESS, BTN_LONG}, 2-bit.
  - Default constants BTN_LONG_TICKS=800, BTN_REPEAT_TICKS=200, BTN_CNT_W=10.
- Single module, no sub-module.
- The 1 ms tick generator is an existing separate block upstream and is not instantiated here.

Test Plan:
All scenarios use LONG_TICKS=4, REPEAT_TICKS=2, tick every 4th clk.
- Hold pressed 5 clks (1 tick), release -> short_pulse=1 and step_pulse=1 exactly 1 cycle after release; no long_pulse.
- Hold 20 ticks -> long_pulse 1 cycle after 4th tick; repeat_pulse after ticks 6, 8, ..., 20 (8 pulses); release -> no short_pulse; long_active falls 1 cycle after release.
- Release in the same cycle as 4th tick -> short_pulse only, long_pulse never asserted.
- REPEAT_TICKS=0, hold 20 ticks -> one long_pulse, zero repeat_pulse; long_active stays 1 until release.
- Assert rst_n=0 mid-LONG with pressed=1 -> all outputs 0 immediately. Release reset with pressed=1 -> state PRESS, long_pulse again after 4 more ticks.
- tick tied high, pressed held 10 clks -> long_pulse after 4th clk in PRESS, repeat_pulse every 2 clks thereafter; pulses never overlap.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and defaults for the digital clock front-panel logic.
// Button event classification constants live here.
package clock_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE  = 2'd0,
    BTN_PRESS = 2'd1,
    BTN_LONG  = 2'd2
  } btn_state_t;

  localparam int unsigned BTN_CNT_W        = 10;
  localparam int unsigned BTN_LONG_TICKS   = 800;
  localparam int unsigned BTN_REPEAT_TICKS = 200;

endpackage

// File: rtl/button_event.sv
// Classifies debounced presses as short/long and emits auto-repeat
// steps while a long press is held.
module button_event
  import clock_pkg::*;
#(
  parameter int unsigned CNT_W        = BTN_CNT_W,
  parameter int unsigned LONG_TICKS   = BTN_LONG_TICKS,
  parameter int unsigned REPEAT_TICKS = BTN_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic pressed,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic step_pulse,
  output logic long_active
);

  localparam longint unsigned CNT_MAX =
    (64'd1 << CNT_W) - 64'd1;

  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_w
    $error("button_event: CNT_W out of range");
  end
  if (LONG_TICKS < 1 ||
      64'(LONG_TICKS) > CNT_MAX) begin : g_bad_long
    $error("button_event: LONG_TICKS out of range");
  end
  if (64'(REPEAT_TICKS) > CNT_MAX) begin : g_bad_rep
    $error("button_event: REPEAT_TICKS out of range");
  end

  localparam bit REP_EN = (REPEAT_TICKS != 0);

  localparam logic [CNT_W-1:0] LONG_LAST =
    CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST =
    CNT_W'(REP_EN ? REPEAT_TICKS - 1 : 0);

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             rep_q, rep_d;
  logic             step_q;
  logic             act_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    unique case (state_q)
      BTN_IDLE: begin
        if (pressed) begin
          state_d = BTN_PRESS;
          cnt_d   = '0;
        end
      end
      BTN_PRESS: begin
        // Release beats a coincident threshold tick.
        if (!pressed) begin
          state_d = BTN_IDLE;
          cnt_d   = '0;
          short_d = 1'b1;
        end else if (tick && cnt_q == LONG_LAST) begin
          state_d = BTN_LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else if (tick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BTN_LONG: begin
        if (!pressed) begin
          state_d = BTN_IDLE;
          cnt_d   = '0;
        end else if (REP_EN && tick) begin
          if (cnt_q == REP_LAST) begin
            cnt_d = '0;
            rep_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = BTN_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BTN_IDLE;
      cnt_q   <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      step_q  <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
      step_q  <= short_d | long_d | rep_d;
      act_q   <= (state_d == BTN_LONG);
    end
  end

  assign short_pulse  = short_q;
  assign long_pulse   = long_q;
  assign repeat_pulse = rep_q;
  assign step_pulse   = step_q;
  assign long_active  = act_q;

endmodule

// File: tb/tb_button_event.sv
// Randomized and directed bench for button_event, two instances:
// repeat enabled (2 ticks) and repeat disabled, both LONG_TICKS=4.
module tb_button_event;

  localparam int LT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic pressed = 1'b0;

  logic a_short, a_long, a_rep, a_step, a_act;
  logic b_short, b_long, b_rep, b_step, b_act;

  always #5 clk = ~clk;

  button_event #(
    .CNT_W(10), .LONG_TICKS(4), .REPEAT_TICKS(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .pressed(pressed),
    .short_pulse(a_short), .long_pulse(a_long),
    .repeat_pulse(a_rep), .step_pulse(a_step),
    .long_active(a_act)
  );

  button_event #(
    .CNT_W(10), .LONG_TICKS(4), .REPEAT_TICKS(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .pressed(pressed),
    .short_pulse(b_short), .long_pulse(b_long),
    .repeat_pulse(b_rep), .step_pulse(b_step),
    .long_active(b_act)
  );

  // {short, long, repeat, step, long_active}
  logic [1:0][4:0] obs;
  assign obs[0] = {a_short, a_long, a_rep, a_step, a_act};
  assign obs[1] = {b_short, b_long, b_rep, b_step, b_act};

  // Model: a press is "active" from the cycle after pressed is seen;
  // held counts ticks seen since then. Long at held==LT, repeat
  // every RT ticks beyond LT, short on release before LT ticks.
  logic [1:0][4:0] exp_v = '0;
  bit m_act [2];
  int m_held [2];

  function automatic int rt_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      bit s, l, r;
      s = 1'b0; l = 1'b0; r = 1'b0;
      if (!rst_n) begin
        m_act[i]  = 1'b0;
        m_held[i] = 0;
      end else if (!m_act[i]) begin
        if (pressed) begin
          m_act[i]  = 1'b1;
          m_held[i] = 0;
        end
      end else if (!pressed) begin
        s = (m_held[i] < LT);
        m_act[i] = 1'b0;
      end else if (tick) begin
        m_held[i]++;
        l = (m_held[i] == LT);
        r = rt_of(i) != 0 && m_held[i] > LT &&
            ((m_held[i] - LT) % rt_of(i)) == 0;
      end
      exp_v[i] = {s, l, r, s | l | r,
                  m_act[i] && m_held[i] >= LT};
    end
  end

  int tests = 0;
  int fails = 0;
  int n_short [2];
  int n_long [2];
  int n_rep [2];

  task automatic chk(input string name, input int act,
                     input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s @%0t: got %0d want %0d",
               name, $time, act, want);
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (obs[i] !== exp_v[i]) begin
        fails++;
        $display("FAIL out[%0d] @%0t: got %b want %b %s",
                 i, $time, obs[i], exp_v[i],
                 "(short,long,rep,step,act)");
      end
      tests++;
      if ($countones(obs[i][4:2]) > 1) begin
        fails++;
        $display("FAIL excl[%0d] @%0t: got %b want onehot0",
                 i, $time, obs[i][4:2]);
      end
      n_short[i] += int'(obs[i][4]);
      n_long[i]  += int'(obs[i][3]);
      n_rep[i]   += int'(obs[i][2]);
    end
  endtask

  task automatic cyc(input logic p, input logic t);
    @(negedge clk);
    compare();
    pressed = p;
    tick = t;
  endtask

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      n_short[i] = 0; n_long[i] = 0; n_rep[i] = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0);
  endtask

  task automatic hold_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0); cyc(1'b1, 1'b1);
    end
  endtask

  task automatic counts(input string tag,
                        input int i, input int s,
                        input int l, input int r);
    chk({tag, "_short"}, n_short[i], s);
    chk({tag, "_long"}, n_long[i], l);
    chk({tag, "_rep"}, n_rep[i], r);
  endtask

  initial begin
    clr();
    idle(3);
    chk("reset_a", int'(obs[0]), 0);
    chk("reset_b", int'(obs[1]), 0);
    cyc(1'b0, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // Short press: 5 clks, one tick.
    clr();
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    @(posedge clk); #1;
    chk("short_lat", int'(a_short), 1);
    chk("short_step", int'(a_step), 1);
    idle(3);
    counts("s1a", 0, 1, 0, 0);

    // Long hold 20 ticks.
    clr();
    cyc(1'b1, 1'b0);
    hold_ticks(20);
    cyc(1'b0, 1'b0);
    chk("act_before_rel", int'(a_act), 1);
    @(posedge clk); #1;
    chk("act_fall_a", int'(a_act), 0);
    chk("act_fall_b", int'(b_act), 0);
    idle(3);
    counts("s2a", 0, 0, 1, 8);
    counts("s2b", 1, 0, 1, 0);

    // Release coincident with the 4th tick.
    clr();
    cyc(1'b1, 1'b0);
    hold_ticks(3);
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    idle(4);
    counts("s3a", 0, 1, 0, 0);
    counts("s3b", 1, 1, 0, 0);

    // Reset in the middle of LONG, pressed still high.
    cyc(1'b1, 1'b0);
    hold_ticks(6);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_a", int'(obs[0]), 0);
    chk("rst_mid_b", int'(obs[1]), 0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    rst_n = 1'b1;
    clr();
    hold_ticks(4);
    cyc(1'b1, 1'b0);
    idle(3);
    counts("s5a", 0, 0, 1, 0);
    counts("s5b", 1, 0, 1, 0);

    // tick tied high, pressed 10 clks.
    clr();
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    idle(3);
    counts("s6a", 0, 0, 1, 2);
    counts("s6b", 1, 0, 1, 0);

    // One-cycle glitch low restarts the press.
    clr();
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    idle(3);
    counts("glitch", 0, 2, 0, 0);

    // Random traffic.
    begin
      logic p, t;
      bit tie;
      p = 1'b0; tie = 1'b0;
      for (int k = 0; k < 4000; k++) begin
        if ($urandom_range(7) == 0) p = ~p;
        if ($urandom_range(199) == 0) tie = ~tie;
        t = tie ? 1'b1 : ($urandom_range(2) == 0);
        cyc(p, t);
        if ($urandom_range(599) == 0) begin
          #2 rst_n = 1'b0;
          cyc(p, t);
          rst_n = 1'b1;
        end
      end
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
